// File: rtl/data_mem_port_master_pkg.sv
// Shared constants and FSM encoding for the data memory port master.
// Default memory depth, word/address widths and the controller state type.
package mem_pkg;

    localparam int unsigned MEM_DEPTH_DEF = 65536;
    localparam int          WORD_W        = 32;
    localparam int          ADDR_W        = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_port_master_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_port_master.sv
// Initiator side of data_memory: one access per core load/store request,
// address range check, held response, and saturating access statistics.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for a request; memory outputs hold last values
// ST_ACCESS | single memory cycle; write strobe only for in-range stores
// ST_RESP   | response held on resp_* until resp_ready retires it
module data_mem_port_master
    import mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic              mem_write_enable,
    output logic [WORD_W-1:0] mem_data_in,
    input  logic [WORD_W-1:0] mem_data_out,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  err_count
);

    // One extra bit so a depth of 2^ADDR_W still compares correctly.
    localparam int                AW1       = ADDR_W + 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = AW1'(MEM_DEPTH);

    state_t              state;
    state_t              state_nx;
    logic                accept;
    logic                retire;

    logic [ADDR_W-1:0]   mem_addr_q;
    logic [WORD_W-1:0]   mem_wdata_q;
    logic                we_q;
    logic                in_range_q;
    logic                resp_valid_q;
    logic [WORD_W-1:0]   resp_rdata_q;
    logic                resp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        req_ready        = 1'b0;
        mem_write_enable = 1'b0;
        accept           = 1'b0;
        retire           = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_write_enable = we_q && in_range_q;
                state_nx         = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    retire   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            we_q         <= 1'b0;
            in_range_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr_q  <= req_addr;
                mem_wdata_q <= req_wdata;
                we_q        <= req_we;
                in_range_q  <= ({1'b0, req_addr} < DEPTH_EXT);
            end
            // Read data is captured from the combinational memory output during ACCESS.
            if (state == ST_ACCESS) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= (!we_q && in_range_q) ? mem_data_out : '0;
                resp_err_q   <= !in_range_q;
            end
            if (retire) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign mem_read_address  = mem_addr_q;
    assign mem_write_address = mem_addr_q;
    assign mem_data_in       = mem_wdata_q;
    assign resp_valid        = resp_valid_q;
    assign resp_rdata        = resp_rdata_q;
    assign resp_err          = resp_err_q;

    sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire && !we_q && in_range_q),
        .count (rd_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire && we_q && in_range_q),
        .count (wr_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire && !in_range_q),
        .count (err_count)
    );

endmodule

// File: tb/tb_data_mem_port_master.sv
// Bench for data_mem_port_master: request-level reference model checked every cycle,
// two DUT instances (16-bit and 2-bit counters) driven with the same directed stimulus.
module tb_data_mem_port_master;

    localparam logic [31:0] DEPTH = 32'd65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        req_ready_a, resp_valid_a, resp_err_a, mem_we_a;
    logic [31:0] resp_rdata_a, mem_raddr_a, mem_waddr_a, mem_din_a, mem_dout_a;
    logic [15:0] rd_cnt_a, wr_cnt_a, err_cnt_a;

    logic        req_ready_b, resp_valid_b, resp_err_b, mem_we_b;
    logic [31:0] resp_rdata_b, mem_raddr_b, mem_waddr_b, mem_din_b, mem_dout_b;
    logic [1:0]  rd_cnt_b, wr_cnt_b, err_cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_port_master #(.MEM_DEPTH(65536), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
        .mem_read_address(mem_raddr_a), .mem_write_address(mem_waddr_a),
        .mem_write_enable(mem_we_a), .mem_data_in(mem_din_a), .mem_data_out(mem_dout_a),
        .rd_count(rd_cnt_a), .wr_count(wr_cnt_a), .err_count(err_cnt_a)
    );

    data_mem_port_master #(.MEM_DEPTH(65536), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .mem_read_address(mem_raddr_b), .mem_write_address(mem_waddr_b),
        .mem_write_enable(mem_we_b), .mem_data_in(mem_din_b), .mem_data_out(mem_dout_b),
        .rd_count(rd_cnt_b), .wr_count(wr_cnt_b), .err_count(err_cnt_b)
    );

    // data_memory stand-in, written only by dut_a; out-of-range reads return junk
    logic [31:0] emu [65536];
    assign mem_dout_a = (mem_raddr_a < DEPTH) ? emu[mem_raddr_a[15:0]] : 32'hBAD0_BAD0;
    assign mem_dout_b = (mem_raddr_b < DEPTH) ? emu[mem_raddr_b[15:0]] : 32'hBAD0_BAD0;

    int wpulses = 0;
    always @(posedge clk) begin
        if (mem_we_a && (mem_waddr_a < DEPTH)) emu[mem_waddr_a[15:0]] <= mem_din_a;
        if (m_init && mem_we_a) wpulses++;
    end

    // ---------------- reference model (request level) ----------------
    logic [31:0] ref_mem [65536];
    bit          m_init = 0;
    bit          m_busy = 0;
    int          m_age = 0;
    bit          m_acc = 0;
    bit          m_we = 0;
    bit          m_inr = 0;
    bit          m_err = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wdata = 0;
    logic [31:0] m_rdata = 0;
    int          m_rd = 0, m_wr = 0, m_er = 0;

    always @(posedge clk) begin
        m_acc = 0;
        if (rst) begin
            m_init = 1; m_busy = 0; m_age = 0;
            m_addr = 0; m_wdata = 0;
            m_rd = 0; m_wr = 0; m_er = 0;
        end else if (m_init) begin
            if (!m_busy) begin
                if (req_valid) begin
                    m_acc = 1; m_busy = 1; m_age = 1;
                    m_we = req_we; m_inr = (req_addr < DEPTH);
                    m_addr = req_addr; m_wdata = req_wdata;
                end
            end else if (m_age == 1) begin
                m_age = 2;
                m_err = !m_inr;
                m_rdata = (!m_we && m_inr) ? ref_mem[m_addr[15:0]] : 32'h0;
                if (m_we && m_inr) ref_mem[m_addr[15:0]] = m_wdata;
            end else if (resp_ready) begin
                m_busy = 0; m_age = 0;
                if (!m_inr) m_er++;
                else if (m_we) m_wr++;
                else m_rd++;
            end
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input logic rdy, input logic vld, input logic [31:0] rdata,
                           input logic err, input logic we, input logic [31:0] ra, input logic [31:0] wa,
                           input logic [31:0] din, input logic [31:0] rc, input logic [31:0] wc,
                           input logic [31:0] ec, input int cmax);
        bit exp_vld;
        exp_vld = m_busy && (m_age == 2);
        chk({tag, ".req_ready"}, {31'b0, rdy}, {31'b0, !m_busy});
        chk({tag, ".resp_valid"}, {31'b0, vld}, {31'b0, exp_vld});
        chk({tag, ".mem_write_enable"}, {31'b0, we}, {31'b0, m_busy && (m_age == 1) && m_we && m_inr});
        chk({tag, ".mem_read_address"}, ra, m_addr);
        chk({tag, ".mem_write_address"}, wa, m_addr);
        chk({tag, ".mem_data_in"}, din, m_wdata);
        if (exp_vld) begin
            chk({tag, ".resp_rdata"}, rdata, m_rdata);
            chk({tag, ".resp_err"}, {31'b0, err}, {31'b0, m_err});
        end
        chk({tag, ".rd_count"}, rc, sat(m_rd, cmax));
        chk({tag, ".wr_count"}, wc, sat(m_wr, cmax));
        chk({tag, ".err_count"}, ec, sat(m_er, cmax));
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            cmp_dut("a", req_ready_a, resp_valid_a, resp_rdata_a, resp_err_a, mem_we_a,
                    mem_raddr_a, mem_waddr_a, mem_din_a,
                    {16'b0, rd_cnt_a}, {16'b0, wr_cnt_a}, {16'b0, err_cnt_a}, 65535);
            cmp_dut("b", req_ready_b, resp_valid_b, resp_rdata_b, resp_err_b, mem_we_b,
                    mem_raddr_b, mem_waddr_b, mem_din_b,
                    {30'b0, rd_cnt_b}, {30'b0, wr_cnt_b}, {30'b0, err_cnt_b}, 3);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data, output int waited);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!m_acc && waited < 50);
        if (!m_acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout actual=none required=accept addr=%h", addr);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_busy) begin
            tests++; fails++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    int w;
    int p0;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            emu[i]     = 32'h1000_0000 + i * 3;
            ref_mem[i] = 32'h1000_0000 + i * 3;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.req_ready", {31'b0, req_ready_a}, 32'd1);
        chk("reset.resp_valid", {31'b0, resp_valid_a}, 32'd0);
        chk("reset.resp_rdata", resp_rdata_a, 32'd0);
        chk("reset.resp_err", {31'b0, resp_err_a}, 32'd0);
        @(posedge clk); #1;

        // store then load at address 5
        p0 = wpulses;
        issue(1'b1, 32'd5, 32'hDEAD_BEEF, w);
        wait_idle();
        chk("store5.write_pulses", wpulses - p0, 32'd1);
        issue(1'b0, 32'd5, 32'h0, w);
        @(posedge clk); #1;
        chk("load5.resp_valid", {31'b0, resp_valid_a}, 32'd1);
        chk("load5.resp_rdata", resp_rdata_a, 32'hDEAD_BEEF);
        chk("load5.resp_err", {31'b0, resp_err_a}, 32'd0);
        wait_idle();

        // top valid address
        issue(1'b0, 32'd65535, 32'h0, w);
        wait_idle();
        issue(1'b1, 32'd65535, 32'hA5A5_5A5A, w);
        wait_idle();
        issue(1'b0, 32'd65535, 32'h0, w);
        @(posedge clk); #1;
        chk("load65535.resp_rdata", resp_rdata_a, 32'hA5A5_5A5A);
        wait_idle();

        // out of range: no write strobe, error response
        p0 = wpulses;
        issue(1'b0, 32'd65536, 32'h0, w);
        @(posedge clk); #1;
        chk("load65536.resp_err", {31'b0, resp_err_a}, 32'd1);
        chk("load65536.resp_rdata", resp_rdata_a, 32'd0);
        wait_idle();
        issue(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, w);
        @(posedge clk); #1;
        chk("storeFFFFFFFF.resp_err", {31'b0, resp_err_a}, 32'd1);
        wait_idle();
        chk("err.write_pulses", wpulses - p0, 32'd0);
        chk("err.err_count", {16'b0, err_cnt_a}, 32'd2);

        // back-pressure: response held, second request ignored
        resp_ready = 1'b0;
        issue(1'b0, 32'd5, 32'h0, w);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'h0BAD_F00D;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("hold.resp_valid", {31'b0, resp_valid_a}, 32'd1);
        chk("hold.resp_rdata", resp_rdata_a, 32'hDEAD_BEEF);
        chk("hold.req_ready", {31'b0, req_ready_a}, 32'd0);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        wait_idle();

        // back-to-back: one accept every third cycle
        issue(1'b0, 32'd100, 32'h0, w);
        issue(1'b1, 32'd101, 32'h0000_0101, w);
        chk("b2b.gap1", w, 32'd3);
        issue(1'b0, 32'd101, 32'h0, w);
        chk("b2b.gap2", w, 32'd3);
        issue(1'b0, 32'd65536, 32'h0, w);
        chk("b2b.gap3", w, 32'd3);
        wait_idle();

        // reset during the ACCESS cycle of a store
        issue(1'b1, 32'd7, 32'h7777_7777, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid.mem_write_enable", {31'b0, mem_we_a}, 32'd0);
        chk("rstmid.req_ready", {31'b0, req_ready_a}, 32'd1);
        chk("rstmid.resp_valid", {31'b0, resp_valid_a}, 32'd0);
        chk("rstmid.mem_write_address", mem_waddr_a, 32'd0);
        chk("rstmid.mem_data_in", mem_din_a, 32'd0);
        chk("rstmid.wr_count", {16'b0, wr_cnt_a}, 32'd0);
        @(posedge clk); #1;

        // five loads: 2-bit counter saturates at 3
        for (int i = 1; i <= 5; i++) begin
            issue(1'b0, i, 32'h0, w);
            wait_idle();
        end
        chk("sat.rd_count_b", {30'b0, rd_cnt_b}, 32'd3);
        chk("sat.wr_count_b", {30'b0, wr_cnt_b}, 32'd0);
        chk("sat.err_count_b", {30'b0, err_cnt_b}, 32'd0);
        chk("sat.rd_count_a", {16'b0, rd_cnt_a}, 32'd5);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
